// File: rtl/max7219_frame_scheduler_pkg.sv
// MAX7219 register map, init words and state encodings shared by the frame scheduler slice.
package max7219_types;

  localparam logic [3:0] HDR              = 4'h0;
  localparam logic [3:0] REG_ROW_0        = 4'h1;
  localparam logic [3:0] REG_ROW_1        = 4'h2;
  localparam logic [3:0] REG_ROW_2        = 4'h3;
  localparam logic [3:0] REG_ROW_3        = 4'h4;
  localparam logic [3:0] REG_ROW_4        = 4'h5;
  localparam logic [3:0] REG_ROW_5        = 4'h6;
  localparam logic [3:0] REG_ROW_6        = 4'h7;
  localparam logic [3:0] REG_ROW_7        = 4'h8;
  localparam logic [3:0] REG_DECODE       = 4'h9;
  localparam logic [3:0] REG_INTENSITY    = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
  localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

  localparam logic [15:0] INIT_DISPLAY_TEST_OFF = {HDR, REG_DISPLAY_TEST, 8'h00};
  localparam logic [15:0] INIT_SCAN_LIMIT       = {HDR, REG_SCAN_LIMIT, 8'h07};
  localparam logic [15:0] INIT_NO_DECODE        = {HDR, REG_DECODE, 8'h00};
  localparam logic [15:0] INIT_NORMAL_OP        = {HDR, REG_SHUTDOWN, 8'h01};
  localparam logic [2:0]  INIT_LAST             = 3'd4;

  typedef enum logic [2:0] {
    RESET_IDLE,
    INIT,
    FRAME_LATCH,
    INTENSITY,
    ROWS,
    WAIT
  } sched_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_LOW,
    SER_HIGH,
    SER_GAP
  } ser_phase_e;

  function automatic logic [15:0] intensity_word(input logic [3:0] level);
    return {HDR, REG_INTENSITY, 4'h0, level};
  endfunction

  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] level);
    case (idx)
      3'd0:    return INIT_DISPLAY_TEST_OFF;
      3'd1:    return INIT_SCAN_LIMIT;
      3'd2:    return INIT_NO_DECODE;
      3'd3:    return intensity_word(level);
      default: return INIT_NORMAL_OP;
    endcase
  endfunction

endpackage

// File: rtl/max7219_serializer.sv
// Shifts one LOAD-low window of N 16-bit words, MSB of the top word first, then holds LOAD high for CLK_DIV cycles.
module max7219_serializer
  import max7219_types::*;
#(
  parameter int unsigned N       = 1,
  parameter int unsigned CLK_DIV = 6
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  input  logic [16*N-1:0]   i_Words,
  output logic              o_DIN,
  output logic              o_CLK,
  output logic              o_LOAD,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam int unsigned BITS = 16 * N;
  localparam int unsigned BW   = $clog2(BITS);
  localparam int unsigned DW   = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS - 1);
  localparam logic [DW-1:0] DIV_RELOAD = DW'(CLK_DIV - 1);

  ser_phase_e      phase_q, phase_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic            din_q, din_d;
  logic            clk_q, clk_d;
  logic            load_q, load_d;
  logic            busy_q, busy_d;
  logic            done;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      phase_q <= SER_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      din_q   <= 1'b0;
      clk_q   <= 1'b0;
      load_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      din_q   <= din_d;
      clk_q   <= clk_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    din_d   = din_q;
    clk_d   = clk_q;
    load_d  = load_q;
    busy_d  = busy_q;
    done    = (phase_q == SER_GAP) && (div_q == '0);

    case (phase_q)
      SER_LOW: begin
        if (div_q == '0) begin
          clk_d   = 1'b1;
          div_d   = DIV_RELOAD;
          phase_d = SER_HIGH;
        end else begin
          div_d = div_q - DW'(1);
        end
      end
      SER_HIGH: begin
        if (div_q == '0) begin
          clk_d = 1'b0;
          div_d = DIV_RELOAD;
          if (bit_q == '0) begin
            load_d  = 1'b1;
            din_d   = 1'b0;
            phase_d = SER_GAP;
          end else begin
            bit_d   = bit_q - BW'(1);
            shift_d = {shift_q[BITS-2:0], 1'b0};
            din_d   = shift_q[BITS-2];
            phase_d = SER_LOW;
          end
        end else begin
          div_d = div_q - DW'(1);
        end
      end
      SER_GAP: begin
        if (div_q == '0) begin
          phase_d = SER_IDLE;
          busy_d  = 1'b0;
        end else begin
          div_d = div_q - DW'(1);
        end
      end
      default: ;
    endcase

    // A start in the last gap cycle chains back-to-back so transactions stay exactly T apart.
    if (i_Start && ((phase_q == SER_IDLE) || done)) begin
      shift_d = i_Words;
      din_d   = i_Words[BITS-1];
      load_d  = 1'b0;
      clk_d   = 1'b0;
      div_d   = DIV_RELOAD;
      bit_d   = BIT_LAST;
      busy_d  = 1'b1;
      phase_d = SER_LOW;
    end
  end

  assign o_DIN  = din_q;
  assign o_CLK  = clk_q;
  assign o_LOAD = load_q;
  assign o_Busy = busy_q;
  assign o_Done = done;

endmodule

// File: rtl/max7219_frame_scheduler.sv
// Runs the MAX7219 init broadcast, then per frame: snapshot, optional intensity update, 8 row transactions, refresh wait.
module max7219_frame_scheduler
  import max7219_types::*;
#(
  parameter int unsigned DISP_ROWS      = 1,
  parameter int unsigned DISP_COLUMNS   = 1,
  parameter int unsigned CLK_DIV        = 6,
  parameter int unsigned REFRESH_CLOCKS = 60000
) (
  input  logic                                             i_Clk,
  input  logic                                             i_Rst_n,
  input  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] i_MAX7219_DataStream,
  input  logic [3:0]                                       i_Intensity,
  output logic                                             o_MAX7219_DIN,
  output logic                                             o_MAX7219_CLK,
  output logic                                             o_MAX7219_LOAD,
  output logic                                             o_Busy,
  output logic                                             o_FrameDone
);

  localparam int unsigned N  = DISP_ROWS * DISP_COLUMNS;
  localparam int unsigned WW = (REFRESH_CLOCKS > 0) ? $clog2(REFRESH_CLOCKS + 1) : 1;
  localparam logic [WW-1:0] WAIT_RELOAD = WW'(REFRESH_CLOCKS - 1);

  sched_state_e           state_q, state_d;
  logic [2:0]             init_q, init_d;
  logic [2:0]             row_q, row_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [3:0]             last_int_q, last_int_d;
  logic [0:7][N-1:0][15:0] snap_q, snap_d;
  logic                   fd_q, fd_d;
  logic                   start;
  logic [N-1:0][15:0]     words;
  logic                   ser_done;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= RESET_IDLE;
      init_q     <= '0;
      row_q      <= '0;
      wait_q     <= '0;
      last_int_q <= '0;
      snap_q     <= '0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      row_q      <= row_d;
      wait_q     <= wait_d;
      last_int_q <= last_int_d;
      snap_q     <= snap_d;
      fd_q       <= fd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    row_d      = row_q;
    wait_d     = wait_q;
    last_int_d = last_int_q;
    snap_d     = snap_q;
    fd_d       = 1'b0;
    start      = 1'b0;
    words      = '0;

    case (state_q)
      RESET_IDLE: begin
        start      = 1'b1;
        words      = {N{init_word(3'd0, i_Intensity)}};
        init_d     = '0;
        last_int_d = i_Intensity;
        state_d    = INIT;
      end
      INIT: begin
        if (ser_done) begin
          if (init_q == INIT_LAST) begin
            state_d = FRAME_LATCH;
          end else begin
            init_d = init_q + 3'd1;
            start  = 1'b1;
            words  = {N{init_word(init_d, last_int_q)}};
          end
        end
      end
      FRAME_LATCH: begin
        // First transaction launches from the live inputs, which equal what the snapshot captures this cycle.
        snap_d = i_MAX7219_DataStream;
        start  = 1'b1;
        if (i_Intensity != last_int_q) begin
          last_int_d = i_Intensity;
          words      = {N{intensity_word(i_Intensity)}};
          state_d    = INTENSITY;
        end else begin
          row_d   = '0;
          words   = i_MAX7219_DataStream[0];
          state_d = ROWS;
        end
      end
      INTENSITY: begin
        if (ser_done) begin
          start   = 1'b1;
          row_d   = '0;
          words   = snap_q[0];
          state_d = ROWS;
        end
      end
      ROWS: begin
        if (ser_done) begin
          if (row_q == 3'd7) begin
            fd_d    = 1'b1;
            wait_d  = WAIT_RELOAD;
            state_d = (REFRESH_CLOCKS == 0) ? FRAME_LATCH : WAIT;
          end else begin
            row_d = row_q + 3'd1;
            start = 1'b1;
            words = snap_q[row_d];
          end
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d = FRAME_LATCH;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      default: state_d = RESET_IDLE;
    endcase
  end

  max7219_serializer #(
    .N       (N),
    .CLK_DIV (CLK_DIV)
  ) u_serializer (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Start (start),
    .i_Words (words),
    .o_DIN   (o_MAX7219_DIN),
    .o_CLK   (o_MAX7219_CLK),
    .o_LOAD  (o_MAX7219_LOAD),
    .o_Busy  (o_Busy),
    .o_Done  (ser_done)
  );

  assign o_FrameDone = fd_q;

endmodule

// File: tb/tb_max7219_frame_scheduler.sv
// Directed bench for a 1x2 chain: decodes each LOAD-low window from DIN on CLK rises and checks words and timing.
module tb_max7219_frame_scheduler;

  logic                        clk;
  logic                        rst_n;
  logic [0:7][0:0][1:0][15:0]  ds;
  logic [3:0]                  intensity;
  logic                        din, sclk, load, busy, fd;

  max7219_frame_scheduler #(
    .DISP_ROWS      (1),
    .DISP_COLUMNS   (2),
    .CLK_DIV        (2),
    .REFRESH_CLOCKS (100)
  ) dut (
    .i_Clk                (clk),
    .i_Rst_n              (rst_n),
    .i_MAX7219_DataStream (ds),
    .i_Intensity          (intensity),
    .o_MAX7219_DIN        (din),
    .o_MAX7219_CLK        (sclk),
    .o_MAX7219_LOAD       (load),
    .o_Busy               (busy),
    .o_FrameDone          (fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          rises;
    int          fall;
  } txn_t;

  txn_t        q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          fd_cyc = 0;
  int          m_rises = 0;
  int          m_fall = 0;
  int          run = 0;
  int          rise_cyc = 0;
  bit          have_rise = 0;
  int          ph_min = 999;
  int          ph_max = 0;
  int          gap_min = 999;
  logic [31:0] m_sh = '0;
  logic        prev_load = 1'b1;
  logic        prev_clk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (fd) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (!rst_n) begin
      m_rises   = 0;
      have_rise = 0;
      prev_load = 1'b1;
      prev_clk  = 1'b0;
    end else begin
      if (prev_load && !load) begin
        m_sh    = '0;
        m_rises = 0;
        m_fall  = cyc;
        run     = 1;
        if (have_rise && (cyc - rise_cyc) < gap_min) gap_min = cyc - rise_cyc;
      end else if (!prev_load) begin
        if (sclk != prev_clk) begin
          if (run < ph_min) ph_min = run;
          if (run > ph_max) ph_max = run;
          run = 1;
        end else begin
          run++;
        end
        if (!prev_clk && sclk && !load) begin
          m_sh = {m_sh[30:0], din};
          m_rises++;
        end
        if (load) begin
          q.push_back('{data: m_sh, rises: m_rises, fall: m_fall});
          have_rise = 1;
          rise_cyc  = cyc;
        end
      end
      prev_load = load;
      prev_clk  = sclk;
    end
  end

  task automatic get_txn(output txn_t t);
    int n = 0;
    while (q.size() == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("txn_arrive", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) t = q.pop_front();
    else t = '{data: '0, rises: 0, fall: 0};
  endtask

  function automatic logic [31:0] row_exp(input int s, input bit changed);
    logic [15:0] hi, lo;
    hi = 16'h01A0 + 16'(s);
    lo = (changed && s == 6) ? 16'h0BEE : 16'h01B0 + 16'(s);
    return {hi, lo};
  endfunction

  task automatic check_init(input logic [3:0] lvl);
    logic [15:0] exp_w [5];
    txn_t t;
    int   f0;
    exp_w = '{16'h0F00, 16'h0B07, 16'h0900, {12'h0A0, lvl}, 16'h0C01};
    for (int k = 0; k < 5; k++) begin
      get_txn(t);
      check($sformatf("init%0d_word", k), t.data, {exp_w[k], exp_w[k]});
      check($sformatf("init%0d_rises", k), 32'(t.rises), 32'd32);
      if (k == 0) f0 = t.fall;
      if (k == 1) check("txn_period", 32'(t.fall - f0), 32'd130);
    end
  endtask

  initial begin
    txn_t t;
    int   f1_fall;
    int   n;

    rst_n     = 1'b0;
    intensity = 4'h5;
    for (int s = 0; s < 8; s++) begin
      ds[s][0][1] = 16'h01A0 + 16'(s);
      ds[s][0][0] = 16'h01B0 + 16'(s);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_din", 32'(din), 32'd0);
    check("rst_clk", 32'(sclk), 32'd0);
    check("rst_load", 32'(load), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_framedone", 32'(fd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    check_init(4'h5);

    // Frame 1; a stream word changed mid-frame must not show up until the next frame.
    f1_fall = 0;
    for (int s = 0; s < 8; s++) begin
      get_txn(t);
      check($sformatf("f1_row%0d", s), t.data, row_exp(s, 1'b0));
      if (s == 0) f1_fall = t.fall;
      if (s == 2) ds[6][0][0] = 16'h0BEE;
    end

    for (int s = 0; s < 8; s++) begin
      get_txn(t);
      check($sformatf("f2_row%0d", s), t.data, row_exp(s, 1'b1));
      if (s == 0) begin
        check("fd_count", 32'(fd_cnt), 32'd1);
        check("fd_to_fall", 32'(t.fall - fd_cyc), 32'd101);
        check("frame_period", 32'(t.fall - f1_fall), 32'd1141);
      end
    end

    n = 0;
    while (fd_cnt < 2 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("fd2_seen", 32'(fd_cnt), 32'd2);
    intensity = 4'hC;

    get_txn(t);
    check("f3_intensity", t.data, 32'h0A0C_0A0C);
    for (int s = 0; s < 8; s++) begin
      get_txn(t);
      check($sformatf("f3_row%0d", s), t.data, row_exp(s, 1'b1));
    end
    get_txn(t);
    check("f4_no_intensity", t.data, row_exp(0, 1'b1));

    // Abort a row transaction while CLK is high for the 10th bit.
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #2;
      if (m_rises == 10 && load == 1'b0) break;
      n++;
    end
    check("bit10_reached", 32'(m_rises), 32'd10);
    rst_n = 1'b0;
    #1;
    check("abort_load", 32'(load), 32'd1);
    check("abort_clk", 32'(sclk), 32'd0);
    check("abort_din", 32'(din), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    q.delete();
    rst_n = 1'b1;

    check_init(4'hC);

    check("phase_min", 32'(ph_min), 32'd2);
    check("phase_max", 32'(ph_max), 32'd2);
    check("gap_ge2", 32'(gap_min >= 2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
